key_schedule_seq: RTL and testbench

- Iterative AES-128 key expander that sits directly upstream of the combinational round stages.
- Accepts a 128-bit cipher key and emits round keys 0..10, one per accepted handshake.
- Round key 0 is the whitening key; rounds 1..9 feed the normal round stage; round 10 feeds the final round stage.
- Uses one SubWord datapath, built from the codebase's four-byte S-box block S4, and a valid/ready output handshake so the round controller can stall it.

---
 rtl/key_schedule_seq.sv | 154 +++++++++++++++
 tb/tb_key_schedule_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// -----------------------------------------------------------------------------
// key_schedule_seq
//   Iterative AES-128 key expander. A start pulse in IDLE captures the cipher
//   key. The block then presents round keys 0..NUM_ROUNDS one at a time on a
//   valid/ready handshake. A single SubWord datapath (s4) produces the next
//   round key from the key currently on rk_out.
//
// Ports
//   clk       in   1    rising-edge clock
//   rst_n     in   1    synchronous active-low reset
//   start     in   1    begin a new expansion (honoured only in IDLE)
//   key_in    in   128  cipher key {w0,w1,w2,w3}, w0 = bits 127:96
//   busy      out  1    expansion in progress
//   rk_valid  out  1    rk_out/rk_round/rk_last are valid
//   rk_ready  in   1    consumer accepts the current round key
//   rk_out    out  128  current round key, same word order as key_in
//   rk_round  out  4    index of rk_out
//   rk_last   out  1    rk_out is the final round key
//
// Also contains s4, the four-byte AES S-box lookup used for SubWord.
// -----------------------------------------------------------------------------

module s4 (
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // NOTE: the S-box is a constant table. It is pure logic and has no storage, so there is nothing to reset.
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

module key_schedule_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_last
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t       state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;

   logic         accept;
   logic         at_last;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sub_w, t_w;
   logic [31:0]  n0, n1, n2, n3;

   // Next round key. This is the only combinational path: rk_q feeds RotWord, then SubWord, then the XOR chain.
   assign {w0, w1, w2, w3} = rk_q;

   s4 u_s4 (
      .din  ({w3[23:0], w3[31:24]}),
      .dout (sub_w)
   );

   assign t_w = sub_w ^ {rcon_q, 24'h0};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   assign at_last = (round_q == 4'(NUM_ROUNDS));
   assign accept  = (state_q == EMIT) && rk_ready;

   // State register. The synchronous reset wins over every other event.
   // NOTE: use non-blocking assignments in clocked blocks so that every flop samples its value from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rk_q    <= '0;
         round_q <= '0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
      end
   end

   // Next-state and datapath update.
   // NOTE: every signal gets a hold default first. Without it, always_comb would infer a latch.
   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EMIT;
               rk_d    = key_in;
               round_d = '0;
               rcon_d  = 8'h01;
            end
         end
         EMIT: begin
            if (accept) begin
               if (at_last) begin
                  // rk_out and rk_round keep the last key after the expansion ends.
                  state_d = IDLE;
               end else begin
                  rk_d    = {n0, n1, n2, n3};
                  round_d = round_q + 4'd1;
                  rcon_d  = rcon_q[7] ? ((rcon_q << 1) ^ 8'h1b) : (rcon_q << 1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from registered state only. rk_ready has no path to any output.
   always_comb begin
      rk_valid = (state_q == EMIT);
      busy     = (state_q == EMIT);
      rk_last  = (state_q == EMIT) && at_last;
      rk_out   = rk_q;
      rk_round = round_q;
   end

endmodule

// File: tb/tb_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// tb_key_schedule_seq
//   Directed bench for key_schedule_seq. Inputs are driven and outputs are
//   sampled on the falling edge of clk. Expected round keys are the published
//   AES-128 schedules for the FIPS-197 example key and for the all-zero key.
// -----------------------------------------------------------------------------

module tb_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         rk_last;

   int n_total = 0;
   int n_bad   = 0;

   logic [127:0] exp_rk [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;
   localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

   key_schedule_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .rk_last  (rk_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic load_fips();
      exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   endtask

   task automatic load_zero();
      exp_rk[0]  = 128'h00000000000000000000000000000000;
      exp_rk[1]  = 128'h62636363626363636263636362636363;
      exp_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
      exp_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
      exp_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
      exp_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
      exp_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
      exp_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
      exp_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
      exp_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
      exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   endtask

   // Runs one expansion of 'key' against exp_rk. Call it at a falling edge with the DUT in IDLE.
   //   stall     : drive a random rk_ready, otherwise hold it at 1
   //   restart4  : pulse start with another key while round 4 is accepted
   //   rst6      : assert rst_n for one cycle when round 6 is presented, then stop
   //   start_end : pulse start in the same cycle that round 10 is accepted
   task automatic expand(input logic [127:0] key, input bit stall, input bit restart4,
                         input bit rst6, input bit start_end);
      int           idx = 0;
      int           cyc = 0;
      bit           stalled = 0;
      logic [127:0] hold_out = '0;
      logic [3:0]   hold_rnd = '0;
      start    = 1'b1;
      key_in   = key;
      rk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("first_valid", 128'(rk_valid), 128'd1);
      check("first_busy", 128'(busy), 128'd1);
      while (idx < 11 && cyc < 200) begin
         if (stalled) begin
            check("stall_out", rk_out, hold_out);
            check("stall_round", 128'(rk_round), 128'(hold_rnd));
            check("stall_valid", 128'(rk_valid), 128'd1);
         end
         if (rst6 && idx == 6) begin
            rst_n    = 1'b0;
            rk_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_mid_valid", 128'(rk_valid), 128'd0);
            check("rst_mid_busy", 128'(busy), 128'd0);
            check("rst_mid_out", rk_out, 128'd0);
            check("rst_mid_round", 128'(rk_round), 128'd0);
            check("rst_mid_last", 128'(rk_last), 128'd0);
            return;
         end
         start    = 1'b0;
         rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rk_valid && rk_ready) begin
            check($sformatf("rk_out_%0d", idx), rk_out, exp_rk[idx]);
            check($sformatf("rk_round_%0d", idx), 128'(rk_round), 128'(idx));
            check($sformatf("rk_last_%0d", idx), 128'(rk_last), 128'(idx == 10));
            if (restart4 && idx == 4) begin
               start  = 1'b1;
               key_in = ALT_KEY;
            end
            if (start_end && idx == 10) begin
               start  = 1'b1;
               key_in = ALT_KEY;
            end
            idx++;
            stalled = 0;
         end else begin
            check("valid_in_emit", 128'(rk_valid), 128'd1);
            stalled  = 1;
            hold_out = rk_out;
            hold_rnd = rk_round;
         end
         @(negedge clk);
         cyc++;
      end
      start    = 1'b0;
      rk_ready = 1'b0;
      check("handshakes", 128'(idx), 128'd11);
      check("end_valid", 128'(rk_valid), 128'd0);
      check("end_busy", 128'(busy), 128'd0);
      check("end_last", 128'(rk_last), 128'd0);
      check("end_out_held", rk_out, exp_rk[10]);
      check("end_round_held", 128'(rk_round), 128'd10);
   endtask

   initial begin
      int cyc;
      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_valid", 128'(rk_valid), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_out", rk_out, 128'd0);
      check("reset_round", 128'(rk_round), 128'd0);
      check("reset_last", 128'(rk_last), 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_valid", 128'(rk_valid), 128'd0);

      // FIPS-197 key with rk_ready held high.
      load_fips();
      expand(FIPS_KEY, 0, 0, 0, 0);

      // All-zero key.
      load_zero();
      expand(ZERO_KEY, 0, 0, 0, 0);

      // FIPS key with random stalls.
      load_fips();
      expand(FIPS_KEY, 1, 0, 0, 0);

      // A start pulse mid-expansion is ignored.
      expand(FIPS_KEY, 0, 1, 0, 0);

      // Reset at round 6, then re-expand from scratch.
      expand(FIPS_KEY, 1, 0, 1, 0);
      expand(FIPS_KEY, 0, 0, 0, 0);

      // A start on the final handshake is ignored. A start one cycle later is honoured.
      expand(FIPS_KEY, 0, 0, 0, 1);
      start  = 1'b1;
      key_in = ALT_KEY;
      @(negedge clk);
      start = 1'b0;
      check("late_start_valid", 128'(rk_valid), 128'd1);
      check("late_start_round", 128'(rk_round), 128'd0);
      check("late_start_out", rk_out, ALT_KEY);
      rk_ready = 1'b1;
      cyc = 0;
      while (rk_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      rk_ready = 1'b0;
      check("late_start_len", 128'(cyc), 128'd11);
      check("late_start_done_busy", 128'(busy), 128'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
